matrix_frame_sched: RTL and testbench
=====================================

Name: matrix_frame_sched

Overview:
- Scheduler and arbiter for the 8x8 LED matrix.
- Two frame sources, e.g. the LFSR pattern and a counter pattern, offer 64-bit frames over valid/ready.
- The block grants the matrix round-robin and holds each granted frame for a minimum number of full scans.
- It performs the row-multiplexed scan itself, driving the rows/columns pins directly.

Parameters:
- ROW_DIV, 65536: i_CLK cycles per row step; must be >= 2.
- DWELL_FRAMES, 64: minimum full 8-row scans of a granted frame before another request may be accepted; must be >= 1.

Ports:
- i_CLK  input  1  system clock; all state on posedge.
- i_RST_N  input  1  reset, asynchronous, active-low.
- i_REQ0_VALID  input  1  requester 0 offers a frame.
- i_REQ0_DATA  input  64  requester 0 frame.
- o_REQ0_READY  output  1  requester 0 frame accepted this cycle if valid.
- i_REQ1_VALID  input  1  requester 1 offers a frame.
- i_REQ1_DATA  input  64  requester 1 frame.
- o_REQ1_READY  output  1  requester 1 frame accepted this cycle if valid.
- i_OE  input  1  display enable; low blanks outputs, counters keep running.
- o_ROWS  output  8  one-hot row select, active-high.
- o_COLUMNS  output  8  column drive, active-low (0 = LED lit).
- o_GRANT  output  2  one-hot owner of the displayed frame; 00 when none.
- o_FRAME_DONE  output  1  one-cycle pulse at the end of each full 8-row scan.

Behaviour:
- Reset (async, i_RST_N=0):
  - Registers: state=IDLE, frame=0, row=0, prescale=0, dwell=0, last=1 (so req0 wins the first tie), o_GRANT=00.
  - Outputs: o_FRAME_DONE=0, o_ROWS=8'h00, o_COLUMNS=8'hFF, READYs=0.
- Reset mid-scan: immediate return to reset values; no partial handshake completes.
- Winner (combinational):
  - Only one VALID high: that requester wins.
  - Both high: the requester != last wins.
  - Neither high: no winner.
- READY: o_REQk_READY = (state is IDLE or SWAP) && k is winner. Transfer occurs on a cycle with VALIDk && READYk.
- A requester may drop VALID before transfer; nothing is latched for it.
- On transfer (next edge):
  - frame <= DATAk, o_GRANT <= one-hot(k), last <= k.
  - row <= 0, prescale <= 0, dwell <= 0, state <= SCAN.
- IDLE: no frame owned; outputs blank; waits for the first transfer.
- SCAN and SWAP timing:
  - prescale counts 0..ROW_DIV-1 and wraps.
  - On wrap, row increments 0..7 and wraps.
  - When row wraps from 7 to 0, o_FRAME_DONE=1 for that one cycle and dwell increments, saturating at DWELL_FRAMES.
- SCAN -> SWAP when dwell reaches DWELL_FRAMES.
- SWAP:
  - The scan of the current frame continues unchanged and READY is offered every cycle.
  - If no requester is valid, the display holds the current frame indefinitely.
  - A transfer restarts at row 0 with the new frame mid-scan; no o_FRAME_DONE for the truncated scan.
- Outputs (combinational from registered state):
  - state != IDLE and i_OE=1: o_ROWS = 1<<row and o_COLUMNS = ~frame[8*row+7 : 8*row], i.e. column c lit iff frame bit 8*row+c is 1.
  - Otherwise: o_ROWS=00, o_COLUMNS=FF.
- Prescale wrap and transfer in the same cycle: the transfer wins and row/prescale clear.
- Full-scan timing: 8*ROW_DIV cycles per full scan. A grant lasts >= 8*ROW_DIV*DWELL_FRAMES cycles.

Test Plan:
- Reset then hold: ROW_DIV=4, DWELL_FRAMES=2, no valids for 100 cycles -> o_ROWS=00, o_COLUMNS=FF, o_GRANT=00, READYs=0 throughout.
- Single request: req0 valid with DATA=64'h0000_0000_0000_00A5 -> READY0 same cycle, o_GRANT=01. Row 0 shows o_COLUMNS=8'h5A for 4 cycles, then rows 1..7 show FF. o_FRAME_DONE pulses every 32 cycles.
- Dwell and round-robin: both valid continuously after the first grant to req0 -> no READY for 64 cycles. Then READY1 fires, o_GRANT=10; after 64 more cycles READY0 fires (alternation).
- Hold without request: after the dwell expires with no valid, the frame is displayed unchanged. Req1 asserting valid at row 5 -> accepted that cycle, next cycle row=0 with the new frame, no o_FRAME_DONE for the cut scan.
- OE blanking: i_OE=0 for rows 2..4 of a scan -> outputs 00/FF. Row timing is unaffected: o_FRAME_DONE still at cycle 32.
- Async reset mid-scan: assert i_RST_N=0 between clock edges during SCAN -> outputs go to reset values immediately; after release, both valid -> req0 wins first.

Source files
------------

// File: rtl/matrix_frame_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_frame_sched: round-robin frame arbiter and row-multiplexed scanner  |
// | for an 8x8 LED matrix.                                      Revision: 1.0  |
// +----------------------------------------------------------------------------+
module matrix_frame_sched #(
  parameter int ROW_DIV      = 65536,
  parameter int DWELL_FRAMES = 64
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_REQ0_VALID,
  input  logic [63:0] i_REQ0_DATA,
  output logic        o_REQ0_READY,
  input  logic        i_REQ1_VALID,
  input  logic [63:0] i_REQ1_DATA,
  output logic        o_REQ1_READY,
  input  logic        i_OE,
  output logic [7:0]  o_ROWS,
  output logic [7:0]  o_COLUMNS,
  output logic [1:0]  o_GRANT,
  output logic        o_FRAME_DONE
);

  localparam int c_PS_W = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam int c_DW_W = $clog2(DWELL_FRAMES + 1);

  localparam logic [c_PS_W-1:0] c_PS_MAX     = c_PS_W'(ROW_DIV - 1);
  localparam logic [c_DW_W-1:0] c_DWELL_MAX  = c_DW_W'(DWELL_FRAMES);
  localparam logic [c_DW_W-1:0] c_DWELL_LAST = c_DW_W'(DWELL_FRAMES - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_SWAP = 2'd2;

  logic [1:0]        r_state;
  logic [63:0]       r_frame;
  logic [2:0]        r_row;
  logic [c_PS_W-1:0] r_prescale;
  logic [c_DW_W-1:0] r_dwell;
  logic              r_last;
  logic [1:0]        r_grant;

  logic w_accepting;
  logic w_any_valid;
  logic w_win;
  logic w_xfer;
  logic w_ps_wrap;
  logic w_frame_done;
  logic w_show;

  // On a tie the requester that did not own the last grant wins.
  assign w_any_valid = i_REQ0_VALID | i_REQ1_VALID;
  assign w_win       = (i_REQ0_VALID & i_REQ1_VALID) ? ~r_last : i_REQ1_VALID;

  // Reset gating keeps READY low while the block is held in reset.
  assign w_accepting  = i_RST_N & ((r_state == c_IDLE) | (r_state == c_SWAP));
  assign w_xfer       = w_accepting & w_any_valid;
  assign o_REQ0_READY = w_accepting & i_REQ0_VALID & ~w_win;
  assign o_REQ1_READY = w_accepting & i_REQ1_VALID &  w_win;

  assign w_ps_wrap    = (r_prescale == c_PS_MAX);
  assign w_frame_done = (r_state != c_IDLE) & w_ps_wrap & (r_row == 3'd7) & ~w_xfer;
  assign o_FRAME_DONE = w_frame_done;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state    <= c_IDLE;
      r_frame    <= '0;
      r_row      <= '0;
      r_prescale <= '0;
      r_dwell    <= '0;
      r_last     <= 1'b1;
      r_grant    <= 2'b00;
    end else if (w_xfer) begin
      r_frame    <= w_win ? i_REQ1_DATA : i_REQ0_DATA;
      r_grant    <= w_win ? 2'b10 : 2'b01;
      r_last     <= w_win;
      r_row      <= '0;
      r_prescale <= '0;
      r_dwell    <= '0;
      r_state    <= c_SCAN;
    end else if (r_state != c_IDLE) begin
      if (w_ps_wrap) begin
        r_prescale <= '0;
        r_row      <= r_row + 3'd1;
      end else begin
        r_prescale <= r_prescale + c_PS_W'(1);
      end
      if (w_frame_done) begin
        if (r_dwell != c_DWELL_MAX) begin
          r_dwell <= r_dwell + c_DW_W'(1);
        end
        // Dwell completes on the edge that closes the last required scan.
        if ((r_state == c_SCAN) && (r_dwell >= c_DWELL_LAST)) begin
          r_state <= c_SWAP;
        end
      end
    end
  end

  assign o_GRANT   = r_grant;
  assign w_show    = (r_state != c_IDLE) & i_OE;
  assign o_ROWS    = w_show ? (8'b1 << r_row) : 8'h00;
  assign o_COLUMNS = w_show ? ~r_frame[{r_row, 3'b000} +: 8] : 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matrix_frame_sched: directed bench for matrix_frame_sched (ROW_DIV=4,   |
// | DWELL_FRAMES=2).                                            Revision: 1.0  |
// +----------------------------------------------------------------------------+
module tb_matrix_frame_sched;

  localparam int ROW_DIV      = 4;
  localparam int DWELL_FRAMES = 2;
  localparam int c_SCAN_LEN   = 8 * ROW_DIV;

  localparam logic [63:0] c_D0A = 64'h0000_0000_0000_00A5;
  localparam logic [63:0] c_D1  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] c_D0B = 64'hF0E1_D2C3_B4A5_9687;
  localparam logic [63:0] c_D2  = 64'h8040_2010_0804_0201;
  localparam logic [63:0] c_D0C = 64'h5555_AAAA_3333_CC3C;

  logic        i_CLK = 1'b0;
  logic        i_RST_N = 1'b0;
  logic        i_REQ0_VALID = 1'b0;
  logic [63:0] i_REQ0_DATA = '0;
  logic        o_REQ0_READY;
  logic        i_REQ1_VALID = 1'b0;
  logic [63:0] i_REQ1_DATA = '0;
  logic        o_REQ1_READY;
  logic        i_OE = 1'b1;
  logic [7:0]  o_ROWS;
  logic [7:0]  o_COLUMNS;
  logic [1:0]  o_GRANT;
  logic        o_FRAME_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_frame_sched #(
    .ROW_DIV      (ROW_DIV),
    .DWELL_FRAMES (DWELL_FRAMES)
  ) u_dut (
    .i_CLK        (i_CLK),
    .i_RST_N      (i_RST_N),
    .i_REQ0_VALID (i_REQ0_VALID),
    .i_REQ0_DATA  (i_REQ0_DATA),
    .o_REQ0_READY (o_REQ0_READY),
    .i_REQ1_VALID (i_REQ1_VALID),
    .i_REQ1_DATA  (i_REQ1_DATA),
    .o_REQ1_READY (o_REQ1_READY),
    .i_OE         (i_OE),
    .o_ROWS       (o_ROWS),
    .o_COLUMNS    (o_COLUMNS),
    .o_GRANT      (o_GRANT),
    .o_FRAME_DONE (o_FRAME_DONE)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed view {rows, cols, grant, done, ready0, ready1}.
  function automatic logic [20:0] outs();
    return {o_ROWS, o_COLUMNS, o_GRANT, o_FRAME_DONE, o_REQ0_READY, o_REQ1_READY};
  endfunction

  // Called just after a transfer edge; cycle k=1 is the first sample after it.
  // Cycles blank_lo..blank_hi are driven with i_OE=0.
  task automatic run_scan(input string tag, input int ncyc, input logic [63:0] frame,
                          input logic [1:0] grant, input int blank_lo, input int blank_hi);
    for (int k = 1; k <= ncyc; k++) begin
      logic [2:0]  row;
      logic        blank;
      logic [7:0]  exp_rows;
      logic [7:0]  exp_cols;
      logic        exp_done;
      @(negedge i_CLK);
      blank = (k >= blank_lo) && (k <= blank_hi);
      i_OE  = ~blank;
      #1;
      row      = 3'(((k - 1) / ROW_DIV) % 8);
      exp_rows = blank ? 8'h00 : (8'h01 << row);
      exp_cols = blank ? 8'hFF : ~frame[{row, 3'b000} +: 8];
      exp_done = ((k % c_SCAN_LEN) == 0);
      check($sformatf("%s k=%0d", tag, k), 64'(outs()),
            64'({exp_rows, exp_cols, grant, exp_done, 1'b0, 1'b0}));
    end
    i_OE = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge i_CLK);
    #1;
    check("reset outputs", 64'(outs()), 64'({8'h00, 8'hFF, 2'b00, 3'b000}));
    @(negedge i_CLK);
    i_RST_N = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 100; i++) begin
      @(negedge i_CLK);
      #1;
      check($sformatf("idle c=%0d", i), 64'(outs()), 64'({8'h00, 8'hFF, 2'b00, 3'b000}));
    end

    // Single request from req0.
    @(negedge i_CLK);
    i_REQ0_VALID = 1'b1;
    i_REQ0_DATA  = c_D0A;
    #1;
    check("ready first req0", 64'({o_REQ0_READY, o_REQ1_READY}), 64'(2'b10));
    @(posedge i_CLK);
    #1;
    check("row0 cols A5", 64'({o_ROWS, o_COLUMNS, o_GRANT}), 64'({8'h01, 8'h5A, 2'b01}));

    // Both valid for the whole dwell; alternation after it.
    i_REQ0_DATA  = c_D0B;
    i_REQ1_VALID = 1'b1;
    i_REQ1_DATA  = c_D1;
    run_scan("dwell0", 2 * c_SCAN_LEN, c_D0A, 2'b01, 0, -1);
    @(negedge i_CLK);
    #1;
    check("swap to req1", 64'(outs()), 64'({8'h01, 8'h5A, 2'b01, 1'b0, 1'b0, 1'b1}));
    @(posedge i_CLK);
    #1;
    run_scan("dwell1", 2 * c_SCAN_LEN, c_D1, 2'b10, 0, -1);
    @(negedge i_CLK);
    #1;
    check("swap back req0", 64'({o_REQ0_READY, o_REQ1_READY, o_GRANT}), 64'({2'b10, 2'b10}));
    @(posedge i_CLK);
    #1;
    i_REQ0_VALID = 1'b0;
    i_REQ1_VALID = 1'b0;

    // Dwell expires with nobody asking; frame holds, then req1 cuts in at row 5.
    run_scan("hold", 3 * c_SCAN_LEN + 5 * ROW_DIV + 1, c_D0B, 2'b01, 0, -1);
    check("hold row5", 64'(o_ROWS), 64'(8'h20));
    i_REQ1_VALID = 1'b1;
    i_REQ1_DATA  = c_D2;
    #1;
    check("ready1 at row5", 64'({o_REQ0_READY, o_REQ1_READY, o_FRAME_DONE}), 64'(3'b010));
    @(posedge i_CLK);
    #1;
    i_REQ1_VALID = 1'b0;

    // New frame restarts at row 0, blanked for rows 2..4.
    run_scan("oe", 40, c_D2, 2'b10, 2 * ROW_DIV + 1, 5 * ROW_DIV);

    // Asynchronous reset between edges.
    @(negedge i_CLK);
    #2;
    i_RST_N      = 1'b0;
    i_REQ0_VALID = 1'b1;
    i_REQ0_DATA  = c_D0C;
    i_REQ1_VALID = 1'b1;
    #1;
    check("async reset", 64'(outs()), 64'({8'h00, 8'hFF, 2'b00, 3'b000}));
    @(posedge i_CLK);
    #1;
    check("held in reset", 64'(outs()), 64'({8'h00, 8'hFF, 2'b00, 3'b000}));
    @(negedge i_CLK);
    i_RST_N = 1'b1;
    #1;
    check("tie after reset", 64'({o_REQ0_READY, o_REQ1_READY}), 64'(2'b10));
    @(posedge i_CLK);
    #1;
    i_REQ0_VALID = 1'b0;
    i_REQ1_VALID = 1'b0;
    @(negedge i_CLK);
    #1;
    check("grant after reset", 64'({o_ROWS, o_COLUMNS, o_GRANT}), 64'({8'h01, 8'hC3, 2'b01}));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
